// File: rtl/hls_main_top_if.sv
// Control/stream bundle for hls_main_top: AXI4 slave register port
// plus input and output AXI-Stream channels.
interface hls_main_top_if #(
  parameter int DATA_W     = 16,
  parameter int USER_W     = 2,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64
) ();
  logic [AXI_ADDR_W-1:0]   axi_s_aw_addr;
  logic [7:0]              axi_s_aw_len;
  logic                    axi_s_aw_valid;
  logic                    axi_s_aw_ready;
  logic [AXI_DATA_W-1:0]   axi_s_w_data;
  logic [AXI_DATA_W/8-1:0] axi_s_w_strb;
  logic                    axi_s_w_last;
  logic                    axi_s_w_valid;
  logic                    axi_s_w_ready;
  logic [1:0]              axi_s_b_resp;
  logic                    axi_s_b_resp_valid;
  logic                    axi_s_b_resp_ready;
  logic [AXI_ADDR_W-1:0]   axi_s_ar_addr;
  logic [7:0]              axi_s_ar_len;
  logic                    axi_s_ar_valid;
  logic                    axi_s_ar_ready;
  logic [AXI_DATA_W-1:0]   axi_s_r_data;
  logic [1:0]              axi_s_r_resp;
  logic                    axi_s_r_last;
  logic                    axi_s_r_valid;
  logic                    axi_s_r_ready;
  logic [DATA_W-1:0]       ififo_tdata;
  logic                    ififo_tlast;
  logic [USER_W-1:0]       ififo_tuser;
  logic                    ififo_valid;
  logic                    ififo_ready;
  logic [DATA_W-1:0]       ofifo_tdata;
  logic                    ofifo_tlast;
  logic [USER_W-1:0]       ofifo_tuser;
  logic                    ofifo_valid;
  logic                    ofifo_ready;

  modport slave (
    input  axi_s_aw_addr, axi_s_aw_len, axi_s_aw_valid,
    output axi_s_aw_ready,
    input  axi_s_w_data, axi_s_w_strb, axi_s_w_last, axi_s_w_valid,
    output axi_s_w_ready,
    output axi_s_b_resp, axi_s_b_resp_valid,
    input  axi_s_b_resp_ready,
    input  axi_s_ar_addr, axi_s_ar_len, axi_s_ar_valid,
    output axi_s_ar_ready,
    output axi_s_r_data, axi_s_r_resp, axi_s_r_last, axi_s_r_valid,
    input  axi_s_r_ready,
    input  ififo_tdata, ififo_tlast, ififo_tuser, ififo_valid,
    output ififo_ready,
    output ofifo_tdata, ofifo_tlast, ofifo_tuser, ofifo_valid,
    input  ofifo_ready
  );

  modport master (
    output axi_s_aw_addr, axi_s_aw_len, axi_s_aw_valid,
    input  axi_s_aw_ready,
    output axi_s_w_data, axi_s_w_strb, axi_s_w_last, axi_s_w_valid,
    input  axi_s_w_ready,
    input  axi_s_b_resp, axi_s_b_resp_valid,
    output axi_s_b_resp_ready,
    output axi_s_ar_addr, axi_s_ar_len, axi_s_ar_valid,
    input  axi_s_ar_ready,
    input  axi_s_r_data, axi_s_r_resp, axi_s_r_last, axi_s_r_valid,
    output axi_s_r_ready,
    output ififo_tdata, ififo_tlast, ififo_tuser, ififo_valid,
    input  ififo_ready,
    input  ofifo_tdata, ofifo_tlast, ofifo_tuser, ofifo_valid,
    output ofifo_ready
  );
endinterface

// File: rtl/hls_main_top.sv
// Streaming add-offset/bypass call engine with AXI4 control registers.
// Define HLS_STATUS_REG_EN to add the STATUS register and frame counter.
module hls_main_top #(
  parameter int DATA_W     = 16,
  parameter int USER_W     = 2,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ready,
  output logic finish,
  hls_main_top_if.slave s
);
  localparam int IDX_W  = AXI_ADDR_W - 3;
  localparam int STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e state_q, state_d;

  logic [16:0]           ctrl_q, ctrl_d;
  logic [16:0]           shadow_q, shadow_d;
  logic [DATA_W-1:0]     o_data_q, o_data_d;
  logic [USER_W-1:0]     o_user_q, o_user_d;
  logic                  o_last_q, o_last_d;
  logic                  o_valid_q, o_valid_d;
  logic                  aw_got_q, aw_got_d;
  logic                  aw_ctrl_q, aw_ctrl_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic                  w_got_q, w_got_d;
  logic                  w_first_q, w_first_d;
  logic [16:0]           w_data_q, w_data_d;
  logic [2:0]            w_strb_q, w_strb_d;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic                  r_valid_q, r_valid_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [AXI_DATA_W-1:0] r_data_q, r_data_d;
  logic [AXI_DATA_W-1:0] rd_val;

  logic in_fire, out_fire, done;
  logic aw_fire, w_fire, ar_fire;
  logic unused_bits;

  assign ready         = (state_q == IDLE);
  assign s.ififo_ready = (state_q == RUN) && (!o_valid_q || s.ofifo_ready);
  assign in_fire       = s.ififo_valid && s.ififo_ready;
  assign out_fire      = o_valid_q && s.ofifo_ready;
  assign done          = (state_q == DRAIN) && out_fire && o_last_q;
  assign finish        = done;

  assign s.ofifo_tdata = o_data_q;
  assign s.ofifo_tuser = o_user_q;
  assign s.ofifo_tlast = o_last_q;
  assign s.ofifo_valid = o_valid_q;

  // Readies stay low while reset is held.
  assign s.axi_s_aw_ready     = !reset && !aw_got_q && !b_valid_q;
  assign s.axi_s_w_ready      = !reset && !w_got_q && !b_valid_q;
  assign s.axi_s_ar_ready     = !reset && !r_valid_q;
  assign s.axi_s_b_resp       = b_resp_q;
  assign s.axi_s_b_resp_valid = b_valid_q;
  assign s.axi_s_r_data       = r_data_q;
  assign s.axi_s_r_resp       = 2'b00;
  assign s.axi_s_r_last       = r_valid_q && (r_cnt_q == 8'd0);
  assign s.axi_s_r_valid      = r_valid_q;

  assign aw_fire = s.axi_s_aw_valid && s.axi_s_aw_ready;
  assign w_fire  = s.axi_s_w_valid && s.axi_s_w_ready;
  assign ar_fire = s.axi_s_ar_valid && s.axi_s_ar_ready;

  assign unused_bits = ^{s.axi_s_aw_addr[2:0], s.axi_s_ar_addr[2:0],
                         s.axi_s_w_data[AXI_DATA_W-1:17],
                         s.axi_s_w_strb[STRB_W-1:3]};

`ifdef HLS_STATUS_REG_EN
  logic [31:0] frames_q, frames_d;

  always_comb begin
    frames_d = frames_q;
    if (done) frames_d = frames_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) frames_q <= '0;
    else       frames_q <= frames_d;
  end
`endif

  always_comb begin
    rd_val = '0;
    if (s.axi_s_ar_addr[AXI_ADDR_W-1:3] == IDX_W'(0)) begin
      rd_val[16:0] = ctrl_q;
    end
`ifdef HLS_STATUS_REG_EN
    else if (s.axi_s_ar_addr[AXI_ADDR_W-1:3] == IDX_W'(1)) begin
      rd_val[32:0] = {state_q != IDLE, frames_q};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (in_fire && s.ififo_tlast) state_d = DRAIN;
      DRAIN:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    shadow_d  = shadow_q;
    o_data_d  = o_data_q;
    o_user_d  = o_user_q;
    o_last_d  = o_last_q;
    o_valid_d = o_valid_q;
    aw_got_d  = aw_got_q;
    aw_ctrl_d = aw_ctrl_q;
    aw_len_d  = aw_len_q;
    w_got_d   = w_got_q;
    w_first_d = w_first_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    r_valid_d = r_valid_q;
    r_cnt_d   = r_cnt_q;
    r_data_d  = r_data_q;

    if (state_q == IDLE && start) shadow_d = ctrl_q;

    if (in_fire) begin
      o_valid_d = 1'b1;
      o_data_d  = shadow_q[16] ? s.ififo_tdata
                : s.ififo_tdata + DATA_W'(shadow_q[15:0]);
      o_user_d  = s.ififo_tuser;
      o_last_d  = s.ififo_tlast;
    end else if (out_fire) begin
      o_valid_d = 1'b0;
    end

    if (aw_fire) begin
      aw_got_d  = 1'b1;
      aw_ctrl_d = (s.axi_s_aw_addr[AXI_ADDR_W-1:3] == IDX_W'(0));
      aw_len_d  = s.axi_s_aw_len;
    end

    // Burst beats after the first are drained but never written.
    if (w_fire) begin
      if (!w_first_q) begin
        w_first_d = 1'b1;
        w_data_d  = s.axi_s_w_data[16:0];
        w_strb_d  = s.axi_s_w_strb[2:0];
      end
      if (s.axi_s_w_last) w_got_d = 1'b1;
    end

    if (aw_got_q && w_got_q) begin
      if (aw_ctrl_q) begin
        if (w_strb_q[0]) ctrl_d[7:0]  = w_data_q[7:0];
        if (w_strb_q[1]) ctrl_d[15:8] = w_data_q[15:8];
        if (w_strb_q[2]) ctrl_d[16]   = w_data_q[16];
      end
      aw_got_d  = 1'b0;
      w_got_d   = 1'b0;
      w_first_d = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = (aw_len_q != 8'd0) ? 2'b10 : 2'b00;
    end

    if (b_valid_q && s.axi_s_b_resp_ready) b_valid_d = 1'b0;

    if (ar_fire) begin
      r_valid_d = 1'b1;
      r_cnt_d   = s.axi_s_ar_len;
      r_data_d  = rd_val;
    end else if (r_valid_q && s.axi_s_r_ready) begin
      if (r_cnt_q == 8'd0) r_valid_d = 1'b0;
      else                 r_cnt_d   = r_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      shadow_q  <= '0;
      o_data_q  <= '0;
      o_user_q  <= '0;
      o_last_q  <= 1'b0;
      o_valid_q <= 1'b0;
      aw_got_q  <= 1'b0;
      aw_ctrl_q <= 1'b0;
      aw_len_q  <= '0;
      w_got_q   <= 1'b0;
      w_first_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= 2'b00;
      r_valid_q <= 1'b0;
      r_cnt_q   <= '0;
      r_data_q  <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      shadow_q  <= shadow_d;
      o_data_q  <= o_data_d;
      o_user_q  <= o_user_d;
      o_last_q  <= o_last_d;
      o_valid_q <= o_valid_d;
      aw_got_q  <= aw_got_d;
      aw_ctrl_q <= aw_ctrl_d;
      aw_len_q  <= aw_len_d;
      w_got_q   <= w_got_d;
      w_first_q <= w_first_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_cnt_q   <= r_cnt_d;
      r_data_q  <= r_data_d;
    end
  end
endmodule

// File: tb/tb_hls_main_top.sv
// Randomized bench for hls_main_top against a frame-level reference model.
// Define HLS_STATUS_REG_EN to expect the STATUS register at address 8.
module tb_hls_main_top;
  logic clk = 1'b0;
  logic reset, start, ready, finish;

  hls_main_top_if bus ();

  hls_main_top dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ready (ready),
    .finish(finish),
    .s     (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [16:0] ctrl_m;
  int frames_m;
  logic [63:0] rd;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // CTRL is a 64-bit byte-strobed word of which only bits 16:0 exist.
  function automatic logic [16:0] merge(input logic [16:0] old,
                                        input logic [63:0] d,
                                        input logic [7:0] st);
    logic [63:0] full;
    full = {47'b0, old};
    for (int b = 0; b < 8; b++)
      if (st[b]) full[b*8 +: 8] = d[b*8 +: 8];
    return full[16:0];
  endfunction

  function automatic logic [63:0] status_exp(input bit busy, input int fr);
    logic [63:0] v;
    v = {31'b0, busy, 32'(fr)};
`ifndef HLS_STATUS_REG_EN
    v = 64'd0;
`endif
    return v;
  endfunction

  task automatic axi_write(input string tag, input logic [31:0] a,
                           input logic [63:0] d, input logic [7:0] st,
                           input logic [7:0] len, input int aw_lag,
                           input int w_lag, input logic [1:0] exp_resp);
    int c;
    fork
      begin
        int ca;
        repeat (aw_lag) @(negedge clk);
        bus.axi_s_aw_addr  = a;
        bus.axi_s_aw_len   = len;
        bus.axi_s_aw_valid = 1'b1;
        #1;
        ca = 0;
        while (!bus.axi_s_aw_ready && ca < 50) begin
          @(negedge clk); #1; ca++;
        end
        check({tag, "_aw_hs"}, bus.axi_s_aw_ready, 1);
        @(negedge clk);
        bus.axi_s_aw_valid = 1'b0;
      end
      begin
        int cw;
        repeat (w_lag) @(negedge clk);
        for (int b = 0; b <= int'(len); b++) begin
          bus.axi_s_w_data  = (b == 0) ? d : ~d;
          bus.axi_s_w_strb  = st;
          bus.axi_s_w_last  = (b == int'(len));
          bus.axi_s_w_valid = 1'b1;
          #1;
          cw = 0;
          while (!bus.axi_s_w_ready && cw < 50) begin
            @(negedge clk); #1; cw++;
          end
          check({tag, "_w_hs"}, bus.axi_s_w_ready, 1);
          @(negedge clk);
        end
        bus.axi_s_w_valid = 1'b0;
      end
    join
    #1;
    c = 0;
    while (!bus.axi_s_b_resp_valid && c < 50) begin
      @(negedge clk); #1; c++;
    end
    check({tag, "_bvalid"}, bus.axi_s_b_resp_valid, 1);
    check({tag, "_bresp"}, bus.axi_s_b_resp, exp_resp);
    bus.axi_s_b_resp_ready = 1'b1;
    @(negedge clk);
    bus.axi_s_b_resp_ready = 1'b0;
    #1;
    check({tag, "_b_once"}, bus.axi_s_b_resp_valid, 0);
    @(negedge clk);
    if (a[31:3] == 29'd0) ctrl_m = merge(ctrl_m, d, st);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] a,
                          input logic [7:0] len, output logic [63:0] data);
    int c, beats;
    logic [63:0] first;
    bus.axi_s_ar_addr  = a;
    bus.axi_s_ar_len   = len;
    bus.axi_s_ar_valid = 1'b1;
    #1;
    c = 0;
    while (!bus.axi_s_ar_ready && c < 50) begin
      @(negedge clk); #1; c++;
    end
    check({tag, "_ar_hs"}, bus.axi_s_ar_ready, 1);
    @(negedge clk);
    bus.axi_s_ar_valid = 1'b0;
    beats = 0;
    c = 0;
    first = '0;
    while (beats <= int'(len) && c < 400) begin
      bus.axi_s_r_ready = 1'($urandom_range(1));
      #1;
      if (bus.axi_s_r_valid && bus.axi_s_r_ready) begin
        if (beats == 0) first = bus.axi_s_r_data;
        else check({tag, "_same"}, bus.axi_s_r_data, first);
        check({tag, "_last"}, bus.axi_s_r_last, beats == int'(len));
        check({tag, "_rresp"}, bus.axi_s_r_resp, 0);
        beats++;
      end
      @(negedge clk);
      c++;
    end
    bus.axi_s_r_ready = 1'b0;
    #1;
    check({tag, "_beats"}, beats, int'(len) + 1);
    check({tag, "_rdone"}, bus.axi_s_r_valid, 0);
    @(negedge clk);
    data = first;
  endtask

  task automatic send_frame(input string tag, input int n,
                            input logic [15:0] base, input bit rnd_data,
                            input bit rnd_bp, input bit gaps);
    logic [15:0] din[$];
    logic [16:0] sh;
    logic [18:0] now_v, held, exp_v;
    logic stall;
    int sent, got, fin, cyc;
    for (int i = 0; i < n; i++)
      din.push_back(rnd_data ? 16'($urandom) : base + 16'(i));
    start = 1'b1;
    #1;
    check({tag, "_start_rdy"}, ready, 1);
    sh = ctrl_m;
    @(negedge clk);
    start = 1'b0;
    sent = 0; got = 0; fin = 0; cyc = 0;
    stall = 1'b0; held = '0;
    while (!(got == n && fin > 0) && cyc < 20 * n + 100) begin
      if (sent < n) begin
        bus.ififo_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
        bus.ififo_tdata = din[sent];
        bus.ififo_tlast = (sent == n - 1);
        bus.ififo_tuser = (sent == 0) ? 2'd1 : 2'd0;
      end else begin
        bus.ififo_valid = 1'b0;
      end
      bus.ofifo_ready = rnd_bp ? 1'($urandom_range(1)) : 1'b1;
      #1;
      now_v = {bus.ofifo_tlast, bus.ofifo_tuser, bus.ofifo_tdata};
      if (stall) begin
        check({tag, "_hold_v"}, bus.ofifo_valid, 1);
        check({tag, "_hold_d"}, now_v, held);
      end
      if (bus.ofifo_valid && !bus.ofifo_ready)
        check({tag, "_in_block"}, bus.ififo_ready, 0);
      if (bus.ofifo_valid && bus.ofifo_ready) begin
        exp_v = {got == n - 1, (got == 0) ? 2'd1 : 2'd0,
                 sh[16] ? din[got] : din[got] + sh[15:0]};
        check({tag, "_beat"}, now_v, exp_v);
        got++;
      end
      if (finish) begin
        fin++;
        check({tag, "_fin_pos"}, got, n);
      end
      if (bus.ififo_valid && bus.ififo_ready) sent++;
      stall = bus.ofifo_valid && !bus.ofifo_ready;
      held = now_v;
      @(negedge clk);
      cyc++;
    end
    bus.ififo_valid = 1'b0;
    repeat (3) begin
      #1;
      if (finish) fin++;
      @(negedge clk);
    end
    check({tag, "_nbeats"}, got, n);
    check({tag, "_one_fin"}, fin, 1);
    check({tag, "_rdy_back"}, ready, 1);
    frames_m++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int fin, cyc;
    logic [63:0] st_exp;
    reset = 1'b1;
    start = 1'b0;
    bus.axi_s_aw_addr = '0; bus.axi_s_aw_len = '0; bus.axi_s_aw_valid = 1'b0;
    bus.axi_s_w_data = '0; bus.axi_s_w_strb = '0; bus.axi_s_w_last = 1'b0;
    bus.axi_s_w_valid = 1'b0; bus.axi_s_b_resp_ready = 1'b0;
    bus.axi_s_ar_addr = '0; bus.axi_s_ar_len = '0; bus.axi_s_ar_valid = 1'b0;
    bus.axi_s_r_ready = 1'b0;
    bus.ififo_tdata = '0; bus.ififo_tlast = 1'b0; bus.ififo_tuser = '0;
    bus.ififo_valid = 1'b0; bus.ofifo_ready = 1'b0;
    ctrl_m = '0;
    frames_m = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_finish", finish, 0);
    check("rst_ovalid", bus.ofifo_valid, 0);
    check("rst_iready", bus.ififo_ready, 0);
    check("rst_axi", {bus.axi_s_aw_ready, bus.axi_s_w_ready,
                      bus.axi_s_ar_ready, bus.axi_s_b_resp_valid,
                      bus.axi_s_r_valid}, 0);
    reset = 1'b0;
    @(negedge clk);

    axi_read("rd_rst", 0, 0, rd);
    check("ctrl_rst", rd, 0);
    axi_write("wr8", 0, 64'd8, 8'hFF, 0, 0, 0, 2'b00);
    axi_read("rd8", 0, 0, rd);
    check("ctrl_8", rd, {47'b0, ctrl_m});
    axi_write("wrbyp", 0, 64'h10000, 8'hFF, 0, 0, 0, 2'b00);
    axi_read("rdbyp", 0, 0, rd);
    check("ctrl_byp", rd, 64'h10000);

    axi_write("wr10", 0, 64'd10, 8'hFF, 0, 0, 0, 2'b00);
    send_frame("off", 100, 16'd0, 0, 0, 0);

    axi_write("wrb2", 0, 64'h10000, 8'hFF, 0, 0, 0, 2'b00);
    fork
      send_frame("byp", 100, 16'd100, 0, 1, 0);
      begin
        repeat (8) @(negedge clk);
        axi_write("wrmid", 0, 64'd5, 8'hFF, 0, 0, 0, 2'b00);
      end
    join
    send_frame("bp", 37, 16'd0, 1, 1, 1);
    send_frame("one", 1, 16'h4321, 0, 1, 0);
    axi_write("wr20", 0, 64'h20, 8'hFF, 0, 0, 0, 2'b00);
    send_frame("wrap", 20, 16'hFFF0, 0, 0, 1);

    axi_write("wr1234", 0, 64'h1234, 8'hFF, 0, 0, 0, 2'b00);
    axi_write("wrstrb", 0, 64'hFF, 8'h01, 0, 3, 0, 2'b00);
    axi_read("rdstrb", 0, 3, rd);
    check("ctrl_12ff", rd, 64'h12FF);
    axi_write("wrwfirst", 0, 64'h0ABC, 8'hFF, 0, 0, 4, 2'b00);
    axi_read("rdwf", 0, 0, rd);
    check("ctrl_abc", rd, {47'b0, ctrl_m});
    axi_write("wrburst", 0, 64'h777, 8'hFF, 1, 0, 0, 2'b10);
    axi_read("rdburst", 0, 0, rd);
    check("ctrl_777", rd, 64'h777);
    axi_write("wrother", 32'h40, 64'h1FFFF, 8'hFF, 0, 0, 0, 2'b00);
    axi_read("rdother", 32'h40, 0, rd);
    check("other_0", rd, 0);
    axi_write("wrstat", 8, 64'hFFFF_FFFF, 8'hFF, 0, 0, 0, 2'b00);
    axi_read("rdctrl2", 0, 0, rd);
    check("ctrl_keep", rd, {47'b0, ctrl_m});
    axi_read("rdstat", 8, 0, rd);
    check("status_5", rd, status_exp(0, frames_m));

    st_exp = status_exp(1, frames_m);
    fork
      send_frame("busy", 50, 16'd7, 1, 1, 0);
      begin
        repeat (10) @(negedge clk);
        axi_read("rdbusy", 8, 1, rd);
        check("status_busy", rd, st_exp);
      end
    join

    // Abort a call mid-frame with the output stalled.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.ififo_valid = 1'b1;
    bus.ififo_tdata = 16'h55;
    bus.ififo_tlast = 1'b0;
    bus.ofifo_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_ovalid", bus.ofifo_valid, 1);
    reset = 1'b1;
    fin = 0;
    repeat (2) begin
      @(negedge clk); #1;
      if (finish) fin++;
    end
    reset = 1'b0;
    bus.ififo_valid = 1'b0;
    check("mid_nofin", fin, 0);
    check("mid_ready", ready, 1);
    check("mid_ovalid0", bus.ofifo_valid, 0);
    @(negedge clk);
    ctrl_m = '0;
    frames_m = 0;
    axi_read("rdmid", 0, 0, rd);
    check("mid_ctrl0", rd, 0);

    bus.ififo_valid = 1'b1;
    bus.ififo_tlast = 1'b1;
    bus.ofifo_ready = 1'b1;
    start = 1'b1;
    fin = 0;
    cyc = 0;
    while (fin < 16800 && cyc < 16800 * 4) begin
      @(negedge clk); #1;
      if (finish) begin
        fin++;
        if (fin == 16800) start = 1'b0;
      end
      cyc++;
    end
    start = 1'b0;
    bus.ififo_valid = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      if (finish) fin++;
    end
    @(negedge clk);
    check("bulk_fin", fin, 16800);
    frames_m += 16800;
    axi_read("rdbulk", 8, 0, rd);
    check("status_bulk", rd, status_exp(0, frames_m));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hls_main_top.md
Name: hls_main_top

Overview:
Single-stage streaming pixel/sample pipeline with an AXI4 slave control register file and an HLS-style start/ready/finish call handshake. Each call consumes one AXI-Stream frame of 16-bit words, terminated by tlast, and emits one transformed word per input word. The transform is add-offset or bypass, selected by a control register.

Parameters:
DATA_W, 16, stream tdata width
USER_W, 2, stream tuser width
AXI_ADDR_W, 32, AXI slave address width
AXI_DATA_W, 64, AXI slave data width; wstrb is AXI_DATA_W/8

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  call request; accepted when start&&ready
ready  out  1  high when idle and able to accept a call
finish  out  1  one-cycle pulse at end of call
AW channel, all in except ready: axi_s_aw_addr in AXI_ADDR_W; axi_s_aw_len in 8; axi_s_aw_valid in 1; axi_s_aw_ready out 1
W channel, all in except ready: axi_s_w_data in 64; axi_s_w_strb in 8; axi_s_w_last in 1; axi_s_w_valid in 1; axi_s_w_ready out 1
B channel: axi_s_b_resp out 2; axi_s_b_resp_valid out 1; axi_s_b_resp_ready in 1
AR channel: axi_s_ar_addr in AXI_ADDR_W; axi_s_ar_len in 8; axi_s_ar_valid in 1; axi_s_ar_ready out 1
R channel: axi_s_r_data out 64; axi_s_r_resp out 2; axi_s_r_last out 1; axi_s_r_valid out 1; axi_s_r_ready in 1
Input stream: ififo_tdata in DATA_W; ififo_tlast in 1; ififo_tuser in USER_W; ififo_valid in 1; ififo_ready out 1
Output stream: ofifo_tdata out DATA_W; ofifo_tlast out 1; ofifo_tuser out USER_W; ofifo_valid out 1; ofifo_ready in 1

Behaviour:
- Reset: CTRL=0, ready=1, finish=0, ofifo_valid=0, ififo_ready=0, all AXI valid/ready outputs=0, frame counter=0.
- Call FSM has three states.
  - IDLE: ready=1. start&&ready latches CTRL into a shadow register, then goes to RUN.
  - RUN: ready=0. ififo_ready = !ofifo_valid || ofifo_ready.
    - On each input beat, the output register loads on the next edge, so latency is 1 cycle.
    - Loaded values: tdata = bypass ? in : (in + CTRL[15:0]) mod 2^16; tuser and tlast pass through.
    - An accepted input beat with tlast=1 goes to DRAIN and drops ififo_ready.
  - DRAIN: when the tlast output beat is accepted (ofifo_valid&&ofifo_ready), pulse finish for 1 cycle and return to IDLE.
    - The frame counter increments on that same cycle.
- Input ififo_tuser is not checked; it passes through as-is.
- A 1-beat frame (first beat carries tlast) is legal. Output is held stable while ofifo_ready=0.
- CTRL register, byte address 0:
  - bits[15:0] offset, bit16 bypass, other bits read 0.
  - Writes honour wstrb and take effect at the next call start.
- Address decode uses addr[AXI_ADDR_W-1:3]. Address 8 is STATUS (see optional feature). Any other address reads 0 and ignores writes, with resp OKAY.
- Write path:
  - aw and w are accepted independently, in the same or different cycles; awready/wready are 1 while that beat is not yet captured.
  - Once both address and data are captured, the register write happens and b_resp_valid is asserted, held until b_resp_ready.
  - No new aw/w is accepted while b_resp_valid is high.
  - aw_len>0: all beats are accepted until w_last, only the first beat writes, and b_resp=2'b10 (SLVERR). Otherwise b_resp=OKAY.
- Read path:
  - ar_ready=1 when no read is in flight.
  - The cycle after acceptance, r_valid=1 with register data and r_resp=OKAY.
  - ar_len+1 beats are returned with identical data; r_last is on the final beat; each beat is held until r_ready.
- AXI writes and reads proceed during RUN without stalling the stream.
- Reset mid-call aborts it with no finish pulse, and all registers return to their reset values.

Optional Feature:
HLS_STATUS_REG_EN defined:
- Address 8 reads STATUS: [31:0] completed-frame count, wrapping at 2^32; [32] busy (state!=IDLE).
- Writes to address 8 are ignored.
Undefined: address 8 reads 0 and no counter logic exists.

Test Plan:
- CTRL reset/readback: read addr 0 after reset -> 0. Write 8 -> read 8. Write 0x10000 -> read 0x10000.
- Offset frame: write 10, then start a 100-beat frame 0..99 (tuser=1 on beat 0, tlast on beat 99) -> output 10..109, tuser on the first beat only, tlast on the last, exactly one finish pulse, ready returns high.
- Bypass frame: CTRL=0x10000, send 100..199 -> output 100..199. A mid-frame CTRL write changes only the next frame.
- Backpressure: toggle ofifo_ready randomly -> no loss or duplication, output stable while stalled, ififo_ready low whenever the output is full and unread.
- AXI edge cases:
  - aw a few cycles before w -> a single b response.
  - wstrb=0x01 writing 0xFF over CTRL=0x1234 -> 0x12FF.
  - aw_len=1 -> b_resp=2'b10.
  - ar_len=3 -> 4 beats, r_last on the 4th.
- Sustained calls/status: 16800 back-to-back calls -> 16800 finish pulses. With HLS_STATUS_REG_EN defined, addr 8 reads 16800 and busy=0. Without it, addr 8 reads 0.
